input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
Conditions the raw mechanical inputs of the bicycle computer before they reach the top-level datapath. It synchronises and debounces the handlebar mode button and classifies each press as short or long. It also synchronises the reed switch and emits exactly one clean pulse per wheel revolution, with a bounce hold-off. Outputs drive the `mode`/`reset`-style control inputs and the `reed` input of the bicycle top and its distance/speed units.

Parameters:
DEBOUNCE_CYCLES, 20, consecutive stable synchronised samples required to accept a button level change
LONG_PRESS_CYCLES, 2000, cycles the button must stay accepted-pressed to count as a long press
REED_HOLDOFF_CYCLES, 50, cycles after an accepted reed edge during which further reed edges are ignored
STALL_CYCLES, 4000, cycles without a reed pulse before reed_stalled asserts (optional feature only)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active-low
mode_raw  input  1  raw button level, 1 = pressed, asynchronous
reed_raw  input  1  raw reed switch level, 1 = magnet present, asynchronous
mode_short  output  1  one-cycle pulse on release of a short press
mode_long  output  1  one-cycle pulse when a press reaches LONG_PRESS_CYCLES
mode_level  output  1  debounced button level
reed_pulse  output  1  one-cycle pulse per accepted reed rising edge
reed_stalled  output  1  no-revolution flag (tied 0 unless REED_STALL_EN)

Behaviour:
- Reset (reset==0 at clock edge): all outputs 0; sync flops 0; all counters 0; button FSM = WAIT_RELEASE; hold-off counter 0.
- Synchronisers: two-flop synchroniser on each raw input. All logic uses the second-stage value (mode_s, reed_s). Latency is 2 cycles before counting starts.
- Counters are sized $clog2(max value + 1) and saturate; they never wrap.
- Button FSM states: WAIT_RELEASE, IDLE, PRESS_DB, HELD, LONG_HELD, RELEASE_DB.
  - WAIT_RELEASE: entered after reset. Stays while mode_s==1, so a button held through reset never produces a press. Goes to IDLE on mode_s==0.
  - IDLE: mode_s==1 -> PRESS_DB with cnt=1.
  - PRESS_DB: cnt increments while mode_s==1. When cnt reaches DEBOUNCE_CYCLES -> HELD, mode_level=1, cnt=0. mode_s==0 before that -> IDLE, cnt=0; a glitch produces no output.
  - HELD: cnt increments each cycle. When cnt reaches LONG_PRESS_CYCLES -> mode_long=1 for one cycle, then LONG_HELD. mode_s==0 -> RELEASE_DB with a tag recording short=1.
  - LONG_HELD: mode_s==0 -> RELEASE_DB with short=0.
  - RELEASE_DB: counts consecutive mode_s==0 cycles. Reaching DEBOUNCE_CYCLES -> IDLE, mode_level=0, and mode_short=1 for one cycle if short==1. mode_s==1 before that -> returns to HELD or LONG_HELD per the tag. The HELD long-press count resumes from where it stopped; it is not cleared.
  - mode_short and mode_long are never asserted in the same cycle. Exactly one of them fires per accepted press.
- Reed path:
  - rising edge of reed_s (reed_s==1, previous==0) while the hold-off counter is 0 -> reed_pulse=1 for one cycle and hold-off counter loaded with REED_HOLDOFF_CYCLES.
  - Hold-off counter decrements to 0. Edges seen while it is non-zero are discarded.
  - Latency from reed_raw rise to reed_pulse is 3 cycles.
  - A reed level held high indefinitely produces one pulse only.
- The button path and the reed path are fully independent; simultaneous events on both are each handled in the same cycle.
- Reset asserted mid-press or mid-hold-off: takes effect at the next edge, with no pulse emitted.

Optional Feature:
REED_STALL_EN
- Defined: a stall counter is cleared on reed_pulse and increments otherwise, saturating. reed_stalled=1 while the count is at or above STALL_CYCLES, and clears in the same cycle reed_pulse is asserted. Reset value is 0; the counter starts at 0.
- Undefined: no stall counter is built and reed_stalled is tied to 0.

Test Plan:
(bench parameters: DEBOUNCE=4, LONG=20, HOLDOFF=8, STALL=40)
1. mode_raw high 3 cycles then low -> no mode_short, no mode_long, mode_level stays 0.
2. mode_raw high 10 cycles then low 10 cycles -> mode_level rises 6 cycles after the press; exactly one mode_short pulse, 4 cycles after the release is synchronised; no mode_long.
3. mode_raw high 40 cycles -> exactly one mode_long, 20 cycles after mode_level rises; on release, no mode_short and mode_level falls.
4. mode_raw held high across reset deassertion, then released, then pressed 10 cycles -> the first hold gives no output; the later press gives one mode_short.
5. reed_raw toggling high/low every cycle for 6 cycles, then steady for 20 cycles, then a second rise -> exactly two reed_pulse, the first 3 cycles after the first rise; edges within the hold-off window are ignored.
6. REED_STALL_EN defined, no reed activity for 45 cycles -> reed_stalled asserts at cycle 40; it clears in the cycle reed_pulse fires on the next reed rise.

Source files
------------

// File: rtl/input_conditioner.sv
// Bicycle computer input conditioner: debounces the mode button into short/long
// presses and turns the reed switch into one pulse per revolution. Macro REED_STALL_EN adds the stall flag.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES     = 20,
  parameter int unsigned LONG_PRESS_CYCLES   = 2000,
  parameter int unsigned REED_HOLDOFF_CYCLES = 50,
  parameter int unsigned STALL_CYCLES        = 4000
) (
  input  logic clock,
  input  logic reset,
  input  logic mode_raw,
  input  logic reed_raw,
  output logic mode_short,
  output logic mode_long,
  output logic mode_level,
  output logic reed_pulse,
  output logic reed_stalled
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int unsigned RH_W   = $clog2(REED_HOLDOFF_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [RH_W-1:0]   RH_LOAD   = RH_W'(REED_HOLDOFF_CYCLES);

  localparam logic [2:0] WAIT_RELEASE = 3'd0;
  localparam logic [2:0] IDLE         = 3'd1;
  localparam logic [2:0] PRESS_DB     = 3'd2;
  localparam logic [2:0] HELD         = 3'd3;
  localparam logic [2:0] LONG_HELD    = 3'd4;
  localparam logic [2:0] RELEASE_DB   = 3'd5;

  logic              mode_s1, mode_s;
  logic              reed_s1, reed_s, reed_prev;
  logic [1:0]        prime_cnt;
  logic              sync_ready;

  logic [2:0]        state, state_nxt;
  logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              short_tag, short_tag_nxt;
  logic              mode_short_nxt, mode_long_nxt, mode_level_nxt;

  logic [RH_W-1:0]   holdoff;
  logic              reed_accept;

  // Two-flop synchronisers; prime_cnt marks when the second stage holds a real sample.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_s1   <= 1'b0;
      mode_s    <= 1'b0;
      reed_s1   <= 1'b0;
      reed_s    <= 1'b0;
      reed_prev <= 1'b0;
      prime_cnt <= 2'd0;
    end else begin
      mode_s1   <= mode_raw;
      mode_s    <= mode_s1;
      reed_s1   <= reed_raw;
      reed_s    <= reed_s1;
      reed_prev <= reed_s;
      if (prime_cnt != 2'd2) prime_cnt <= prime_cnt + 2'd1;
    end
  end

  // Without this, the reset-zeroed synchroniser would look like a release of a held button.
  assign sync_ready = (prime_cnt == 2'd2);

  // Button state register and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= WAIT_RELEASE;
      db_cnt     <= '0;
      hold_cnt   <= '0;
      short_tag  <= 1'b0;
      mode_short <= 1'b0;
      mode_long  <= 1'b0;
      mode_level <= 1'b0;
    end else begin
      state      <= state_nxt;
      db_cnt     <= db_cnt_nxt;
      hold_cnt   <= hold_cnt_nxt;
      short_tag  <= short_tag_nxt;
      mode_short <= mode_short_nxt;
      mode_long  <= mode_long_nxt;
      mode_level <= mode_level_nxt;
    end
  end

  // Button next-state logic; the hold count survives release bounces.
  always_comb begin
    state_nxt      = state;
    db_cnt_nxt     = db_cnt;
    hold_cnt_nxt   = hold_cnt;
    short_tag_nxt  = short_tag;
    mode_short_nxt = 1'b0;
    mode_long_nxt  = 1'b0;
    mode_level_nxt = mode_level;
    case (state)
      WAIT_RELEASE: begin
        if (sync_ready && !mode_s) state_nxt = IDLE;
      end
      IDLE: begin
        if (mode_s) begin
          state_nxt  = PRESS_DB;
          db_cnt_nxt = DB_W'(1);
        end
      end
      PRESS_DB: begin
        if (!mode_s) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt >= DB_LAST) begin
          state_nxt      = HELD;
          mode_level_nxt = 1'b1;
          db_cnt_nxt     = '0;
          hold_cnt_nxt   = '0;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      HELD: begin
        if (!mode_s) begin
          state_nxt     = RELEASE_DB;
          db_cnt_nxt    = DB_W'(1);
          short_tag_nxt = 1'b1;
        end else if (hold_cnt >= HOLD_LAST) begin
          state_nxt     = LONG_HELD;
          mode_long_nxt = 1'b1;
          hold_cnt_nxt  = HOLD_MAX;
        end else begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      LONG_HELD: begin
        if (!mode_s) begin
          state_nxt     = RELEASE_DB;
          db_cnt_nxt    = DB_W'(1);
          short_tag_nxt = 1'b0;
        end
      end
      RELEASE_DB: begin
        if (mode_s) begin
          state_nxt  = short_tag ? HELD : LONG_HELD;
          db_cnt_nxt = '0;
        end else if (db_cnt >= DB_LAST) begin
          state_nxt      = IDLE;
          mode_level_nxt = 1'b0;
          mode_short_nxt = short_tag;
          db_cnt_nxt     = '0;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      default: begin
        state_nxt = WAIT_RELEASE;
      end
    endcase
  end

  // Reed edge is accepted only when the hold-off window has fully expired.
  assign reed_accept = reed_s && !reed_prev && (holdoff == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      reed_pulse <= 1'b0;
      holdoff    <= '0;
    end else begin
      reed_pulse <= reed_accept;
      if (reed_accept) begin
        holdoff <= RH_LOAD;
      end else if (holdoff != '0) begin
        holdoff <= holdoff - RH_W'(1);
      end
    end
  end

`ifdef REED_STALL_EN
  localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

  logic [STALL_W-1:0] stall_cnt, stall_cnt_nxt;

  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (reed_accept) begin
      stall_cnt_nxt = '0;
    end else if (stall_cnt < STALL_MAX) begin
      stall_cnt_nxt = stall_cnt + STALL_W'(1);
    end
  end

  // Flag tracks the next count so it drops in the same cycle as reed_pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt    <= '0;
      reed_stalled <= 1'b0;
    end else begin
      stall_cnt    <= stall_cnt_nxt;
      reed_stalled <= (stall_cnt_nxt >= STALL_MAX);
    end
  end
`else
  assign reed_stalled = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal expectations plus
// random button/reed activity compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_input_conditioner;

  localparam int unsigned DEB   = 4;
  localparam int unsigned LONG  = 20;
  localparam int unsigned HOLD  = 8;
  localparam int unsigned STALL = 40;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic mode_raw = 1'b0;
  logic reed_raw = 1'b0;
  logic mode_short, mode_long, mode_level, reed_pulse, reed_stalled;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES    (DEB),
    .LONG_PRESS_CYCLES  (LONG),
    .REED_HOLDOFF_CYCLES(HOLD),
    .STALL_CYCLES       (STALL)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mode_raw    (mode_raw),
    .reed_raw    (reed_raw),
    .mode_short  (mode_short),
    .mode_long   (mode_long),
    .mode_level  (mode_level),
    .reed_pulse  (reed_pulse),
    .reed_stalled(reed_stalled)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: level flips after DEB consecutive disagreeing samples;
  // a press is long once it has been held LONG samples; reed edges need HOLD quiet edges.
  int  t, run, held, last_reed, since;
  bit  ms1, ms2, rs1, rs2, rprev, lvl, long_done, armed, model_valid;
  bit  cur_mode, cur_reed;
  bit  exp_short, exp_long, exp_level, exp_pulse, exp_stalled;

  always @(posedge clock) begin
    if (!reset) begin
      t = 0; run = 0; held = 0; last_reed = -1000; since = 0;
      ms1 = 0; ms2 = 0; rs1 = 0; rs2 = 0; rprev = 0;
      lvl = 0; long_done = 0; armed = 0; model_valid = 1;
      exp_short = 0; exp_long = 0; exp_level = 0; exp_pulse = 0; exp_stalled = 0;
    end else begin
      t++;
      cur_mode = ms2;
      cur_reed = rs2;
      exp_short = 0;
      exp_long = 0;
      if (!armed) begin
        if (t >= 3 && !cur_mode) armed = 1;
      end else if (cur_mode != lvl) begin
        run++;
        if (run >= int'(DEB)) begin
          lvl = cur_mode;
          run = 0;
          if (lvl) begin
            held = 0;
            long_done = 0;
          end else if (!long_done) begin
            exp_short = 1;
          end
        end
      end else begin
        if (lvl && run == 0 && !long_done) begin
          held++;
          if (held >= int'(LONG)) begin
            exp_long = 1;
            long_done = 1;
          end
        end
        run = 0;
      end
      exp_level = lvl;
      exp_pulse = 0;
      if (cur_reed && !rprev && (t - last_reed) > int'(HOLD)) begin
        exp_pulse = 1;
        last_reed = t;
      end
      rprev = cur_reed;
      if (exp_pulse) since = 0;
      else if (since < int'(STALL)) since++;
`ifdef REED_STALL_EN
      exp_stalled = (since >= int'(STALL));
`else
      exp_stalled = 0;
`endif
      ms2 = ms1; ms1 = mode_raw;
      rs2 = rs1; rs1 = reed_raw;
    end
  end

  // Per-cycle comparison and event bookkeeping for the directed checks.
  int n_short, n_long, n_rise, t_short, t_long, t_rise, t_stall;
  int pulses[$];
  bit prev_level, prev_stalled, stall_at_pulse, stall_before_pulse;

  always @(negedge clock) begin
    if (model_valid) begin
      check_bit("mode_short", mode_short, exp_short);
      check_bit("mode_long", mode_long, exp_long);
      check_bit("mode_level", mode_level, exp_level);
      check_bit("reed_pulse", reed_pulse, exp_pulse);
      check_bit("reed_stalled", reed_stalled, exp_stalled);
    end
    if (mode_short === 1'b1) begin n_short++; t_short = cyc; end
    if (mode_long === 1'b1) begin n_long++; t_long = cyc; end
    if (mode_level === 1'b1 && !prev_level) begin n_rise++; t_rise = cyc; end
    if (reed_stalled === 1'b1 && !prev_stalled) t_stall = cyc;
    if (reed_pulse === 1'b1) begin
      pulses.push_back(cyc);
      stall_at_pulse = reed_stalled;
      stall_before_pulse = prev_stalled;
    end
    prev_level = (mode_level === 1'b1);
    prev_stalled = (reed_stalled === 1'b1);
  end

  task automatic clear_events();
    n_short = 0; n_long = 0; n_rise = 0;
    t_short = -1; t_long = -1; t_rise = -1; t_stall = -1;
    pulses.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  int c0, c1, r_edge, stop_cyc;

  initial begin
    clear_events();
    step(3);
    reset = 1'b1;
    step(5);

    // Short glitch: rejected.
    clear_events();
    mode_raw = 1'b1; step(3);
    mode_raw = 1'b0; step(15); #1;
    check_int("t1_short_count", n_short, 0);
    check_int("t1_long_count", n_long, 0);
    check_int("t1_level_rises", n_rise, 0);

    // Short press.
    clear_events();
    c0 = cyc;
    mode_raw = 1'b1; step(10);
    mode_raw = 1'b0; step(20); #1;
    check_int("t2_level_rises", n_rise, 1);
    check_int("t2_level_latency", t_rise - c0, 6);
    check_int("t2_short_count", n_short, 1);
    check_int("t2_short_latency", t_short - c0, 16);
    check_int("t2_long_count", n_long, 0);
    check_bit("t2_level_after", mode_level, 1'b0);

    // Long press.
    clear_events();
    c0 = cyc;
    mode_raw = 1'b1; step(40);
    mode_raw = 1'b0; step(20); #1;
    check_int("t3_long_count", n_long, 1);
    check_int("t3_long_after_level", t_long - t_rise, 20);
    check_int("t3_long_latency", t_long - c0, 26);
    check_int("t3_short_count", n_short, 0);
    check_bit("t3_level_after", mode_level, 1'b0);

    // Held through reset, then a real press.
    clear_events();
    mode_raw = 1'b1; step(1);
    reset = 1'b0; step(2);
    reset = 1'b1; step(10);
    mode_raw = 1'b0; step(10);
    mode_raw = 1'b1; step(10);
    mode_raw = 1'b0; step(20); #1;
    check_int("t4_level_rises", n_rise, 1);
    check_int("t4_short_count", n_short, 1);
    check_int("t4_long_count", n_long, 0);

    // Bouncing reed then a second clean rise.
    clear_events();
    c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      reed_raw = (i % 2 == 0);
      step(1);
    end
    reed_raw = 1'b0; step(20);
    c1 = cyc;
    reed_raw = 1'b1; step(10);
    reed_raw = 1'b0; step(12); #1;
    check_int("t5_pulse_count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      check_int("t5_first_latency", pulses[0] - c0, 3);
      check_int("t5_second_latency", pulses[1] - c1, 3);
    end

    // Stall flag after a quiet period.
    clear_events();
    reset = 1'b0; step(1);
    r_edge = cyc;
    reset = 1'b1; step(45); #1;
`ifdef REED_STALL_EN
    check_int("t6_stall_edge", t_stall - r_edge, 40);
    check_bit("t6_stalled", reed_stalled, 1'b1);
`else
    check_int("t6_stall_edge", t_stall, -1);
    check_bit("t6_stalled", reed_stalled, 1'b0);
`endif
    c1 = cyc;
    reed_raw = 1'b1; step(5); #1;
    check_int("t6_pulse_count", pulses.size(), 1);
    if (pulses.size() == 1) check_int("t6_pulse_latency", pulses[0] - c1, 3);
    check_bit("t6_stall_at_pulse", stall_at_pulse, 1'b0);
`ifdef REED_STALL_EN
    check_bit("t6_stall_before_pulse", stall_before_pulse, 1'b1);
`endif
    reed_raw = 1'b0;
    step(10);

    // Random activity on both inputs with one mid-run reset.
    stop_cyc = cyc + 4000;
    fork
      begin
        int len, nb;
        while (cyc < stop_cyc) begin
          mode_raw = 1'($urandom_range(0, 1));
          len = int'($urandom_range(1, 60));
          step(len);
          if ($urandom_range(0, 3) == 0) begin
            nb = int'($urandom_range(1, 6));
            for (int j = 0; j < nb; j++) begin
              mode_raw = ~mode_raw;
              step(1);
            end
          end
        end
        mode_raw = 1'b0;
      end
      begin
        int len, nb;
        while (cyc < stop_cyc) begin
          reed_raw = 1'($urandom_range(0, 1));
          len = int'($urandom_range(1, 30));
          step(len);
          if ($urandom_range(0, 2) == 0) begin
            nb = int'($urandom_range(1, 5));
            for (int j = 0; j < nb; j++) begin
              reed_raw = ~reed_raw;
              step(1);
            end
          end
        end
        reed_raw = 1'b0;
      end
      begin
        step(1777);
        reset = 1'b0;
        step(2);
        reset = 1'b1;
      end
    join
    step(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
